// File: rtl/dbg_uart_pkg.sv
// Shared constants and state encoding for the debug UART transmitter.
// Build option: DBG_UART_PARITY_EN adds an even-parity bit to every frame.
package dbg_uart_pkg;

    localparam logic [31:0] TXDATA_ADDR = 32'hF000_00D0;
    localparam logic [31:0] STATUS_ADDR = 32'hF000_00D4;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_IE    = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef DBG_UART_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } uart_state_e;

`ifdef DBG_UART_PARITY_EN
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

endpackage

// File: rtl/dbg_uart_tx_if.sv
// Core data-bus slice seen by the debug UART: address, write data, lane enables, read data.
// Signal suffixes are from the UART's point of view.
interface dbg_uart_tx_if;

    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  data_w_i;
    logic [31:0] data_o;

    modport master (
        output addr_i,
        output data_i,
        output data_w_i,
        input  data_o
    );

    modport slave (
        input  addr_i,
        input  data_i,
        input  data_w_i,
        output data_o
    );

endinterface

// File: rtl/dbg_fifo.sv
// Byte FIFO with extra-MSB pointers; head word is visible on dout_o without a pop.
// Synchronous active-low reset clears the pointers only.
module dbg_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               din_i,
    output logic [7:0]               dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        wr_en;
    logic        rd_en;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (count_o == (AW + 1)'(DEPTH));

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/dbg_uart_tx.sv
// Memory-mapped debug console: TXDATA bytes are queued and sent as 8N1 on tx_o.
// Build option: DBG_UART_PARITY_EN inserts an even-parity bit after the data bits.
module dbg_uart_tx
    import dbg_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 217,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dbg_uart_tx_if.slave  bus,
    output logic          tx_o,
    output logic          irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH);

    uart_state_e  state_q;
    logic [15:0]  baud_q;
    logic [2:0]   bit_q;
    logic [7:0]   shift_q;
    logic         tx_q;
    logic         irq_q;
    logic         ovf_q;
    logic         ovf_d;
    logic         ie_q;
    logic         ie_d;
    logic [31:0]  rdata_q;
    logic [31:0]  rdata_d;
`ifdef DBG_UART_PARITY_EN
    logic         parity_q;
`endif

    logic         bus_we;
    logic [7:0]   wr_byte;
    logic         txdata_wr;
    logic         status_wr;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [7:0]   fifo_dout;
    logic [CW:0]  fifo_count;
    logic         push_drop;
    logic         busy;
    logic         baud_tick;
    logic [7:0]   status_byte;
    logic         unused_bits;

    assign bus_we    = |bus.data_w_i;
    assign wr_byte   = bus.data_i[31:24];
    assign txdata_wr = (bus.addr_i == TXDATA_ADDR) && bus_we;
    assign status_wr = (bus.addr_i == STATUS_ADDR) && bus_we;

    assign busy      = (state_q != S_IDLE);
    assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;
    assign push_drop = txdata_wr && fifo_full && !fifo_pop;
    assign baud_tick = (baud_q == 16'(CLK_DIV - 1));

    // Only the top byte lane and the FIFO flags carry information here.
    assign unused_bits = ^{bus.data_i[23:0], fifo_count};

    dbg_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (txdata_wr),
        .pop_i   (fifo_pop),
        .din_i   (wr_byte),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        status_byte           = '0;
        status_byte[ST_FULL]  = fifo_full;
        status_byte[ST_EMPTY] = fifo_empty;
        status_byte[ST_BUSY]  = busy;
        status_byte[ST_OVF]   = ovf_q;
        status_byte[ST_IE]    = ie_q;
    end

    always_comb begin
        ovf_d   = ovf_q;
        ie_d    = ie_q;
        rdata_d = '0;
        if (push_drop) begin
            ovf_d = 1'b1;
        end
        if (status_wr) begin
            if (wr_byte[ST_OVF]) begin
                ovf_d = 1'b0;
            end
            ie_d = wr_byte[ST_IE];
        end
        if (bus.addr_i == STATUS_ADDR) begin
            rdata_d = {status_byte, 24'h0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ovf_q   <= 1'b0;
            ie_q    <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            ovf_q   <= ovf_d;
            ie_q    <= ie_d;
            rdata_q <= rdata_d;
            irq_q   <= ie_q && fifo_empty && !busy;
        end
    end

    // Serializer: every state or bit change restarts the baud counter.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef DBG_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q  <= fifo_dout;
`ifdef DBG_UART_PARITY_EN
                        parity_q <= even_parity(fifo_dout);
`endif
                        tx_q     <= 1'b0;
                        baud_q   <= '0;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_q   <= '0;
                        baud_q  <= '0;
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef DBG_UART_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
`ifdef DBG_UART_PARITY_EN
                S_PARITY: begin
                    if (baud_tick) begin
                        tx_q    <= 1'b1;
                        baud_q  <= '0;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_tick) begin
                        tx_q    <= 1'b1;
                        baud_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_o = rdata_q;
    assign tx_o       = tx_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_dbg_uart_tx.sv
// Self-checking bench for dbg_uart_tx: directed frame/status/irq/reset cases plus
// randomized bus traffic decoded from tx_o and matched against an expected-byte queue.
module tb_dbg_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 16;
`ifdef DBG_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CLK_DIV;
    localparam logic [31:0] A_TX = 32'hF000_00D0;
    localparam logic [31:0] A_ST = 32'hF000_00D4;
    localparam logic [31:0] A_NM = 32'hF000_00D8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    logic irq;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    dbg_uart_tx_if bus_if ();

    dbg_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_if),
        .tx_o  (tx),
        .irq_o (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected line levels of one frame, index 0 = start bit.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef DBG_UART_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    function automatic logic [31:0] st(input logic full, input logic empty, input logic busy,
                                       input logic ovf, input logic ie);
        return {3'b000, ie, ovf, busy, empty, full, 24'h0};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        bus_if.addr_i   = a;
        bus_if.data_i   = d;
        bus_if.data_w_i = we;
        tick(1);
        bus_if.addr_i   = '0;
        bus_if.data_i   = '0;
        bus_if.data_w_i = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_if.addr_i   = a;
        bus_if.data_w_i = '0;
        tick(1);
        d = bus_if.data_o;
        bus_if.addr_i = '0;
    endtask

    // Decode n frames from tx_o by mid-bit sampling and match against exp_q.
    task automatic rx_bytes(input int n);
        int w;
        logic [10:0] got;
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (tx !== 1'b0 && w < 3000) begin
                tick(1);
                w++;
            end
            if (tx !== 1'b0) begin
                check_eq("rx_start", 32'(tx), 32'd0);
                return;
            end
            got = '1;
            for (int k = 1; k < FRAME_CYC; k++) begin
                tick(1);
                if (k % CLK_DIV == CLK_DIV / 2) got[k / CLK_DIV] = tx;
            end
            if (exp_q.size() == 0) begin
                check_eq("rx_queue", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                $display("[TB] rx byte 0x%02h frame %b", e, got);
                check_eq("rx_frame", 32'(got), 32'(frame_of(e)));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [7:0] b;
        logic [10:0] f;
        int flag;
        int n_valid;
        logic [31:0] r_addr[24];
        logic [31:0] r_data[24];
        logic [3:0]  r_we[24];
        int          r_gap[24];

        // Reset state, with STATUS on the bus so a missing reset of data_o shows.
        bus_if.addr_i   = A_ST;
        bus_if.data_i   = '0;
        bus_if.data_w_i = '0;
        rst_n = 1'b0;
        tick(3);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_data_o", bus_if.data_o, 32'd0);
        rst_n = 1'b1;
        bus_read(A_ST, d);
        check_eq("rst_status", d, st(0, 1, 0, 0, 0));
        tick(2);

        // Single byte, exact cycle waveform.
        b = 8'h41;
        f = frame_of(b);
        bus_write(A_TX, 32'h4100_0000, 4'hF);
        check_eq("t1_pre", 32'(tx), 32'd1);
        for (int k = 0; k < FRAME_CYC; k++) begin
            tick(1);
            check_eq("t1_tx", 32'(tx), 32'(f[k / CLK_DIV]));
        end
        tick(1);
        bus_read(A_ST, d);
        check_eq("t1_done", d, st(0, 1, 0, 0, 0));
        $display("[TB] single byte 0x41 sent");

        // Burst of 18: 17 accepted (first is popped at once), 18th overflows.
        for (int i = 0; i < 17; i++) exp_q.push_back(i[7:0]);
        fork
            rx_bytes(17);
            begin
                for (int i = 0; i < 18; i++) begin
                    bus_if.addr_i   = A_TX;
                    bus_if.data_i   = {i[7:0], 24'h00_5A5A};
                    bus_if.data_w_i = 4'h1;
                    tick(1);
                end
                bus_if.data_w_i = '0;
                bus_read(A_ST, d);
                check_eq("burst_status", d, st(1, 0, 1, 1, 0));
                bus_write(A_ST, 32'h0800_0000, 4'h8);
                bus_read(A_ST, d);
                check_eq("ovf_clear", d, st(1, 0, 1, 0, 0));
            end
        join
        check_eq("burst_drain", 32'(exp_q.size()), 32'd0);
        tick(3);

        // Interrupt: high while idle with ie, low for the whole frame, high after STOP.
        bus_write(A_ST, 32'h1000_0000, 4'hF);
        tick(1);
        check_eq("irq_idle", 32'(irq), 32'd1);
        b = 8'($urandom);
        f = frame_of(b);
        bus_write(A_TX, {b, 24'h0}, 4'h2);
        flag = 0;
        n_valid = 0;
        for (int k = 1; k <= FRAME_CYC + 1; k++) begin
            tick(1);
            if (irq !== 1'b0) flag = 1;
            if (k <= FRAME_CYC && tx !== f[(k - 1) / CLK_DIV]) n_valid++;
        end
        check_eq("irq_frame", 32'(flag), 32'd0);
        check_eq("irq_tx_wave", 32'(n_valid), 32'd0);
        tick(1);
        check_eq("irq_drained", 32'(irq), 32'd1);
        bus_write(A_TX, 32'h3300_0000, 4'hF);
        tick(1);
        check_eq("irq_drop", 32'(irq), 32'd0);
        tick(FRAME_CYC + 5);
        bus_write(A_ST, 32'h0000_0000, 4'hF);
        tick(1);
        check_eq("irq_ie_off", 32'(irq), 32'd0);
        $display("[TB] interrupt sequence done (byte 0x%02h)", b);

        // Unmapped address: no push, no frame, data_o reads zero.
        bus_write(A_NM, 32'h5500_0000, 4'hF);
        flag = 0;
        for (int k = 0; k < 60; k++) begin
            tick(1);
            if (tx !== 1'b1) flag = 1;
        end
        check_eq("unmapped_tx", 32'(flag), 32'd0);
        bus_read(A_ST, d);
        check_eq("unmapped_status", d, st(0, 1, 0, 0, 0));
        bus_read(A_NM, d);
        check_eq("unmapped_read", d, 32'd0);

        // Randomized bus traffic: valid pushes, zero-lane writes, stray addresses.
        n_valid = 0;
        for (int i = 0; i < 24; i++) begin
            int kind;
            kind = int'($urandom_range(0, 7));
            r_gap[i] = int'($urandom_range(0, 25));
            r_data[i] = $urandom;
            if (kind <= 4 && n_valid < 12) begin
                r_addr[i] = A_TX;
                r_we[i]   = 4'($urandom_range(1, 15));
                exp_q.push_back(r_data[i][31:24]);
                n_valid++;
            end else if (kind == 5) begin
                r_addr[i] = A_TX;
                r_we[i]   = 4'h0;
            end else begin
                r_addr[i] = (kind == 6) ? (A_NM + 32'($urandom_range(0, 9) << 2)) : $urandom;
                if (r_addr[i] == A_TX || r_addr[i] == A_ST) r_addr[i] = 32'h0;
                r_we[i] = 4'($urandom_range(1, 15));
            end
        end
        fork
            rx_bytes(n_valid);
            begin
                for (int i = 0; i < 24; i++) begin
                    $display("[TB] op %0d addr 0x%08h data 0x%08h we %h", i, r_addr[i], r_data[i], r_we[i]);
                    bus_write(r_addr[i], r_data[i], r_we[i]);
                    tick(r_gap[i]);
                end
            end
        join
        check_eq("rnd_drain", 32'(exp_q.size()), 32'd0);
        tick(3);
        bus_read(A_ST, d);
        check_eq("rnd_status", d, st(0, 1, 0, 0, 0));

`ifdef DBG_UART_PARITY_EN
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        fork
            rx_bytes(2);
            begin
                bus_write(A_TX, 32'h0700_0000, 4'hF);
                bus_write(A_TX, 32'h0300_0000, 4'hF);
            end
        join
        check_eq("par_drain", 32'(exp_q.size()), 32'd0);
        tick(3);
`endif

        // Reset during DATA bit 3 of a 0x00 byte with the FIFO full and overflow set.
        for (int i = 0; i < 18; i++) begin
            bus_if.addr_i   = A_TX;
            bus_if.data_i   = (i == 0) ? 32'h0 : $urandom;
            bus_if.data_w_i = 4'hF;
            tick(1);
        end
        bus_if.data_w_i = '0;
        bus_if.addr_i   = A_ST;
        check_eq("pre_rst_tx", 32'(tx), 32'd0);
        rst_n = 1'b0;
        tick(1);
        check_eq("midrst_tx", 32'(tx), 32'd1);
        check_eq("midrst_irq", 32'(irq), 32'd0);
        check_eq("midrst_data_o", bus_if.data_o, 32'd0);
        rst_n = 1'b1;
        tick(1);
        bus_read(A_ST, d);
        check_eq("midrst_status", d, st(0, 1, 0, 0, 0));
        flag = 0;
        for (int k = 0; k < 60; k++) begin
            tick(1);
            if (tx !== 1'b1) flag = 1;
        end
        check_eq("midrst_flushed", 32'(flag), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dbg_uart_tx.md
Name: dbg_uart_tx

Overview:
- Memory-mapped debug console transmitter that consumes the core's character writes to 0xF00000D0.
- Buffers each written byte in a small FIFO and serializes it as 8N1 UART on tx_o.
- Sits on the core data bus beside the peripherals block; its read data is muxed into the core's data_i by the SoC top.
- Gives a real serial console in place of the simulation-only print.

Parameters:
- CLK_DIV, 217, clock cycles per UART bit (25 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 16, FIFO entries; power of two, 2..256.

Ports:
- clk_i  input  1  single system clock, rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- addr_i  input  32  core byte address.
- data_i  input  32  core write data, core byte order; the character is data_i[31:24].
- data_w_i  input  4  core byte-lane write enables; any lane set means write.
- data_o  output  32  registered read data, core byte order.
- tx_o  output  1  UART serial out; idle high.
- irq_o  output  1  level interrupt: transmitter drained.

Behaviour:
- Reset (rst_i=0 at a clk_i edge): FIFO empty, FSM IDLE, tx_o=1, irq_o=0, data_o=0, overflow=0, ie=0. A reset during a frame aborts it; tx_o is 1 on the next cycle.
- Register map:
  - TXDATA at 0xF00000D0 (write only).
  - STATUS at 0xF00000D4 (read/write).
  - Any other address is ignored, and data_o=0 the next cycle.
- TXDATA write (addr_i==TXDATA and data_w_i!=0): data_i[31:24] is pushed.
  - The push is accepted if the FIFO is not full, or if the FSM pops in the same cycle.
  - Otherwise the byte is dropped and sticky overflow is set.
- STATUS read: data_o[31:24] carries the status byte, so it lines up with the core's byte order.
  - bit0 full.
  - bit1 empty.
  - bit2 busy (FSM not IDLE).
  - bit3 overflow.
  - bit4 ie.
  - All other bits are 0.
  - data_o is registered: the value is valid the cycle after the address is presented.
- STATUS write, using data_i[31:24]:
  - bit3 written 1 clears overflow.
  - bit4 loads ie.
  - Other bits are ignored.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
  - START: tx_o=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, each held CLK_DIV cycles. A 3-bit counter counts bits; exit after bit 7.
  - STOP: tx_o=1 for CLK_DIV cycles, then IDLE. A back-to-back byte leaves IDLE after one cycle.
  - Baud counter: 16 bits, reloads to 0 on every state/bit change, advances at count==CLK_DIV-1.
- Latency: a write accepted at edge N gives an empty→non-empty FIFO after N. The FSM pops at N+1, and tx_o=0 (start bit) from N+1 onward. Frame length is 10*CLK_DIV cycles (+1 idle cycle).
- tx_o is driven from a register, so it is glitch-free.
- irq_o = ie & empty & ~busy, registered (one-cycle lag).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; wrap-around is natural modulo.
- Simultaneous push and pop while full: the count is unchanged and no overflow occurs.
- Simultaneous push and pop while empty: not possible, because a pop requires non-empty.

Optional Feature:
- Macro: DBG_UART_PARITY_EN.
- Defined: the PARITY state is inserted after DATA. It sends even parity (XOR of the 8 data bits) for CLK_DIV cycles, and the frame becomes 11*CLK_DIV.
- Undefined: there is no PARITY state, the frame is 8N1, and no parity logic is generated.

Decomposition:
- Package dbg_uart_pkg holds:
  - TXDATA_ADDR and STATUS_ADDR constants.
  - Status bit index constants (ST_FULL=0, ST_EMPTY=1, ST_BUSY=2, ST_OVF=3, ST_IE=4).
  - The FSM state enum.
- Sub-module dbg_fifo: synchronous FIFO with ports push, pop, din[7:0], dout[7:0], full, empty, and count, parameterized by depth. It uses the same clock and the same reset convention.

Test Plan:
- Single byte, CLK_DIV=4: write 0x41000000 to 0xF00000D0 → tx_o bit sequence 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles, start bit beginning one cycle after the write edge; then busy=0.
- Burst of 17 bytes (0x00..0x10), FIFO_DEPTH=16, with no pops yet:
  - The first byte is popped at N+1, so all 17 are accepted.
  - An 18th write immediately after sets overflow.
  - A STATUS read returns full=1 and ovf=1.
  - Writing STATUS with bit3=1 clears ovf.
- Interrupt: set ie via STATUS=0x10000000, then send one byte → irq_o=0 during the frame and 1 one cycle after STOP completes; a further write drops irq_o.
- Reset mid-frame: pull rst_i low during DATA bit 3 → next cycle tx_o=1, STATUS reads empty=1, busy=0, ovf=0, data_o=0.
- Parity (DBG_UART_PARITY_EN defined): send 0x07 → parity bit 1 and stop after 11*CLK_DIV; send 0x03 → parity bit 0.
- Non-matching address: write to 0xF00000D8 → no push and tx_o stays 1; reading an unmapped address → data_o=0.
